// File: rtl/vx_wb_pkg.sv
// Shared types and helpers for the multi-lane writeback arbiter.
package vx_wb_pkg;

    localparam logic [7:0] ARB_RR   = "R";
    localparam logic [7:0] ARB_PRIO = "P";

    localparam int WB_NUM_THREADS = 4;
    localparam int WB_NW_BITS     = 2;
    localparam int WB_NR_BITS     = 6;

    // Layout of one commit/lane payload at the default sizing; the flat
    // vectors in the top use the same MSB-to-LSB field order.
    typedef struct packed {
        logic [WB_NW_BITS-1:0]        wid;
        logic [31:0]                  PC;
        logic [WB_NUM_THREADS-1:0]    tmask;
        logic [WB_NR_BITS-1:0]        rd;
        logic [WB_NUM_THREADS*32-1:0] data;
        logic                         eop;
    } wb_req_t;

    function automatic int wb_req_width(input int nw_bits, input int nr_bits,
                                        input int num_threads);
        return nw_bits + 32 + num_threads + nr_bits + num_threads * 32 + 1;
    endfunction

endpackage

// File: rtl/vx_wb_grant_scan.sv
// Combinational multi-grant scan: up to NUM_WB_PORTS grants starting at start_i,
// skipping any source whose (wid, rd) matches an earlier grant this cycle.
module vx_wb_grant_scan
    import vx_wb_pkg::*;
#(
    parameter int NUM_REQS     = 6,
    parameter int NUM_WB_PORTS = 2,
    parameter int NW_BITS      = 2,
    parameter int NR_BITS      = 6
) (
    input  logic [NUM_REQS-1:0]         eligible_i,
    input  logic [NUM_REQS*NW_BITS-1:0] wid_i,
    input  logic [NUM_REQS*NR_BITS-1:0] rd_i,
    input  logic [((NUM_REQS > 1) ? $clog2(NUM_REQS) : 1)-1:0] start_i,
    output logic [NUM_REQS-1:0]         grant_o,
    output logic [NUM_REQS*((NUM_WB_PORTS > 1) ? $clog2(NUM_WB_PORTS) : 1)-1:0] lane_idx_o,
    output logic [((NUM_REQS > 1) ? $clog2(NUM_REQS) : 1)-1:0] last_idx_o,
    output logic                        any_grant_o
);

    localparam int IDX_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int LANE_W = (NUM_WB_PORTS > 1) ? $clog2(NUM_WB_PORTS) : 1;
    localparam int CNT_W  = $clog2(NUM_WB_PORTS + 1);

    always_comb begin : scan
        logic [NUM_REQS-1:0] gnt;
        logic [CNT_W-1:0]    cnt;
        logic                hit;
        int                  idx;
        gnt         = '0;
        cnt         = '0;
        hit         = 1'b0;
        idx         = 0;
        lane_idx_o  = '0;
        last_idx_o  = '0;
        any_grant_o = 1'b0;
        for (int k = 0; k < NUM_REQS; k++) begin
            idx = int'(start_i) + k;
            if (idx >= NUM_REQS) idx = idx - NUM_REQS;
            hit = 1'b0;
            for (int j = 0; j < NUM_REQS; j++) begin
                if (gnt[j] && wid_i[j*NW_BITS +: NW_BITS] == wid_i[idx*NW_BITS +: NW_BITS]
                           && rd_i[j*NR_BITS +: NR_BITS] == rd_i[idx*NR_BITS +: NR_BITS])
                    hit = 1'b1;
            end
            if (eligible_i[idx] && int'(cnt) < NUM_WB_PORTS && !hit) begin
                gnt[idx]                        = 1'b1;
                lane_idx_o[idx*LANE_W +: LANE_W] = LANE_W'(cnt);
                cnt                             = cnt + CNT_W'(1);
                last_idx_o                      = IDX_W'(idx);
                any_grant_o                     = 1'b1;
            end
        end
        grant_o = gnt;
    end

endmodule

// File: rtl/vx_writeback_multi.sv
// N commit sources onto M registered writeback lanes; latency 1 from accept to lane.
// Any lane valid & not ready stalls every lane and acknowledges no writeback source.
module vx_writeback_multi
    import vx_wb_pkg::*;
#(
    parameter int         NUM_REQS     = 6,
    parameter int         NUM_WB_PORTS = 2,
    parameter int         NUM_THREADS  = 4,
    parameter int         NW_BITS      = 2,
    parameter int         NR_BITS      = 6,
    parameter logic [7:0] ARB_MODE     = ARB_RR,
    parameter int         PERF_W       = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQS-1:0]                  in_valid,
    input  logic [NUM_REQS-1:0]                  in_wb,
    input  logic [NUM_REQS*NW_BITS-1:0]          in_wid,
    input  logic [NUM_REQS*32-1:0]               in_PC,
    input  logic [NUM_REQS*NUM_THREADS-1:0]      in_tmask,
    input  logic [NUM_REQS*NR_BITS-1:0]          in_rd,
    input  logic [NUM_REQS*NUM_THREADS*32-1:0]   in_data,
    input  logic [NUM_REQS-1:0]                  in_eop,
    output logic [NUM_REQS-1:0]                  in_ready,
    output logic [NUM_WB_PORTS-1:0]              out_valid,
    output logic [NUM_WB_PORTS*NW_BITS-1:0]      out_wid,
    output logic [NUM_WB_PORTS*32-1:0]           out_PC,
    output logic [NUM_WB_PORTS*NUM_THREADS-1:0]  out_tmask,
    output logic [NUM_WB_PORTS*NR_BITS-1:0]      out_rd,
    output logic [NUM_WB_PORTS*NUM_THREADS*32-1:0] out_data,
    output logic [NUM_WB_PORTS-1:0]              out_eop,
    input  logic [NUM_WB_PORTS-1:0]              out_ready,
    output logic [PERF_W-1:0]                    perf_wb_count
);

    localparam int REQ_W     = wb_req_width(NW_BITS, NR_BITS, NUM_THREADS);
    localparam int DATA_W    = NUM_THREADS * 32;
    localparam int IDX_W     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int LANE_W    = (NUM_WB_PORTS > 1) ? $clog2(NUM_WB_PORTS) : 1;
    localparam int DATA_OFF  = 1;
    localparam int RD_OFF    = DATA_OFF + DATA_W;
    localparam int TMASK_OFF = RD_OFF + NR_BITS;
    localparam int PC_OFF    = TMASK_OFF + NUM_THREADS;
    localparam int WID_OFF   = PC_OFF + 32;

    logic [NUM_REQS*REQ_W-1:0]     req_flat;
    logic [NUM_REQS-1:0]           eligible;
    logic [NUM_REQS-1:0]           grant;
    logic [NUM_REQS*LANE_W-1:0]    lane_idx;
    logic [IDX_W-1:0]              last_idx;
    logic                          any_grant;
    logic [IDX_W-1:0]              scan_start;
    logic                          stall;

    logic [NUM_WB_PORTS-1:0]       out_valid_q, lane_vld_d;
    logic [NUM_WB_PORTS*REQ_W-1:0] out_req_q, lane_req_d;
    logic [IDX_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [PERF_W-1:0]             perf_q, perf_d;

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_pack
        assign req_flat[i*REQ_W +: REQ_W] = {in_wid[i*NW_BITS +: NW_BITS], in_PC[i*32 +: 32],
                                             in_tmask[i*NUM_THREADS +: NUM_THREADS],
                                             in_rd[i*NR_BITS +: NR_BITS],
                                             in_data[i*DATA_W +: DATA_W], in_eop[i]};
    end

    assign eligible   = in_valid & in_wb;
    assign scan_start = (ARB_MODE == ARB_PRIO) ? '0 : rr_ptr_q;
    assign stall      = |(out_valid_q & ~out_ready);

    vx_wb_grant_scan #(
        .NUM_REQS     (NUM_REQS),
        .NUM_WB_PORTS (NUM_WB_PORTS),
        .NW_BITS      (NW_BITS),
        .NR_BITS      (NR_BITS)
    ) u_scan (
        .eligible_i  (eligible),
        .wid_i       (in_wid),
        .rd_i        (in_rd),
        .start_i     (scan_start),
        .grant_o     (grant),
        .lane_idx_o  (lane_idx),
        .last_idx_o  (last_idx),
        .any_grant_o (any_grant)
    );

    // Non-writeback commits retire immediately, stalled or not; nothing acks in reset.
    assign in_ready = reset ? ((in_valid & ~in_wb) | (grant & {NUM_REQS{~stall}})) : '0;

    always_comb begin
        lane_vld_d = '0;
        lane_req_d = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            for (int m = 0; m < NUM_WB_PORTS; m++) begin
                if (grant[i] && lane_idx[i*LANE_W +: LANE_W] == LANE_W'(m)) begin
                    lane_vld_d[m]                = 1'b1;
                    lane_req_d[m*REQ_W +: REQ_W] = req_flat[i*REQ_W +: REQ_W];
                end
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (!stall && any_grant)
            rr_ptr_d = (int'(last_idx) == NUM_REQS - 1) ? '0 : last_idx + IDX_W'(1);
        perf_d = perf_q;
        for (int m = 0; m < NUM_WB_PORTS; m++) begin
            if (out_valid_q[m] && out_ready[m]) perf_d = perf_d + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q <= '0;
            rr_ptr_q    <= '0;
            perf_q      <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            perf_q   <= perf_d;
            if (!stall) out_valid_q <= lane_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) out_req_q <= lane_req_d;
    end

    for (genvar m = 0; m < NUM_WB_PORTS; m++) begin : g_unpack
        assign out_wid[m*NW_BITS +: NW_BITS]         = out_req_q[m*REQ_W + WID_OFF +: NW_BITS];
        assign out_PC[m*32 +: 32]                    = out_req_q[m*REQ_W + PC_OFF +: 32];
        assign out_tmask[m*NUM_THREADS +: NUM_THREADS] = out_req_q[m*REQ_W + TMASK_OFF +: NUM_THREADS];
        assign out_rd[m*NR_BITS +: NR_BITS]          = out_req_q[m*REQ_W + RD_OFF +: NR_BITS];
        assign out_data[m*DATA_W +: DATA_W]          = out_req_q[m*REQ_W + DATA_OFF +: DATA_W];
        assign out_eop[m]                            = out_req_q[m*REQ_W];
    end

    assign out_valid     = out_valid_q;
    assign perf_wb_count = perf_q;

endmodule

// File: tb/tb_vx_writeback_multi.sv
module tb_vx_writeback_multi;
    localparam int N = 6, M = 2, NT = 4, NW = 2, NR = 6, PW = 32;
    localparam int DW = NT * 32;
    localparam int RW = NW + 32 + NT + NR + DW + 1;

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0]      in_valid, in_wb, in_eop, in_ready, p_in_ready;
    logic [N*NW-1:0]   in_wid;
    logic [N*32-1:0]   in_PC;
    logic [N*NT-1:0]   in_tmask;
    logic [N*NR-1:0]   in_rd;
    logic [N*DW-1:0]   in_data;
    logic [M-1:0]      out_ready;
    logic [M-1:0]      out_valid, out_eop, p_out_valid, p_out_eop;
    logic [M*NW-1:0]   out_wid, p_out_wid;
    logic [M*32-1:0]   out_PC, p_out_PC;
    logic [M*NT-1:0]   out_tmask, p_out_tmask;
    logic [M*NR-1:0]   out_rd, p_out_rd;
    logic [M*DW-1:0]   out_data, p_out_data;
    logic [PW-1:0]     perf, p_perf;

    int checks = 0, errors = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    vx_writeback_multi #(.ARB_MODE("R")) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_wb(in_wb), .in_wid(in_wid),
        .in_PC(in_PC), .in_tmask(in_tmask), .in_rd(in_rd), .in_data(in_data), .in_eop(in_eop),
        .in_ready(in_ready), .out_valid(out_valid), .out_wid(out_wid), .out_PC(out_PC),
        .out_tmask(out_tmask), .out_rd(out_rd), .out_data(out_data), .out_eop(out_eop),
        .out_ready(out_ready), .perf_wb_count(perf));

    vx_writeback_multi #(.ARB_MODE("P")) dut_p (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_wb(in_wb), .in_wid(in_wid),
        .in_PC(in_PC), .in_tmask(in_tmask), .in_rd(in_rd), .in_data(in_data), .in_eop(in_eop),
        .in_ready(p_in_ready), .out_valid(p_out_valid), .out_wid(p_out_wid), .out_PC(p_out_PC),
        .out_tmask(p_out_tmask), .out_rd(p_out_rd), .out_data(p_out_data), .out_eop(p_out_eop),
        .out_ready(out_ready), .perf_wb_count(p_perf));

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] src_vec(input int i);
        return {in_wid[i*NW +: NW], in_PC[i*32 +: 32], in_tmask[i*NT +: NT],
                in_rd[i*NR +: NR], in_data[i*DW +: DW], in_eop[i]};
    endfunction

    function automatic logic [RW-1:0] lane_vec(input int k);
        return {out_wid[k*NW +: NW], out_PC[k*32 +: 32], out_tmask[k*NT +: NT],
                out_rd[k*NR +: NR], out_data[k*DW +: DW], out_eop[k]};
    endfunction

    function automatic logic [NW+NR-1:0] key(input int i);
        return {in_wid[i*NW +: NW], in_rd[i*NR +: NR]};
    endfunction

    // Reference model: lane contents as a list of captured commits, pointer as an int.
    logic [M-1:0]  m_valid = '0, n_valid = '0;
    logic [RW-1:0] m_lane[M], n_lane[M];
    int            m_rr = 0, n_rr = 0;
    logic [PW-1:0] m_perf = '0, n_perf = '0;

    always @(negedge clk) begin : model
        int          gl[$];
        logic        st, dup;
        logic [N-1:0] er;
        int          idx;
        gl = {};
        st = |(m_valid & ~out_ready);
        for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (in_valid[idx] && in_wb[idx] && gl.size() < M) begin
                dup = 1'b0;
                foreach (gl[j]) if (key(gl[j]) == key(idx)) dup = 1'b1;
                if (!dup) gl.push_back(idx);
            end
        end
        er = '0;
        if (reset) begin
            for (int i = 0; i < N; i++) er[i] = in_valid[i] && !in_wb[i];
            foreach (gl[j]) if (!st) er[gl[j]] = 1'b1;
        end
        if (chk_en) begin
            chk("model_in_ready", 256'(in_ready), 256'(er));
            chk("model_out_valid", 256'(out_valid), 256'(m_valid));
            for (int k = 0; k < M; k++)
                if (m_valid[k]) chk("model_lane", 256'(lane_vec(k)), 256'(m_lane[k]));
            chk("model_perf", 256'(perf), 256'(m_perf));
        end
        n_valid = m_valid; n_lane = m_lane; n_rr = m_rr; n_perf = m_perf;
        if (!reset) begin
            n_valid = '0; n_rr = 0; n_perf = '0;
        end else begin
            for (int k = 0; k < M; k++) if (m_valid[k] && out_ready[k]) n_perf = n_perf + 1;
            if (!st) begin
                n_valid = '0;
                foreach (gl[j]) begin
                    n_valid[j] = 1'b1;
                    n_lane[j]  = src_vec(gl[j]);
                end
                if (gl.size() > 0) n_rr = (gl[gl.size()-1] + 1) % N;
            end
        end
    end

    always @(posedge clk) begin
        m_valid <= n_valid; m_lane <= n_lane; m_rr <= n_rr; m_perf <= n_perf;
    end

    task automatic set_src(input int i, input bit wb, input int wid, input int rd, input int tag);
        in_valid[i]       = 1'b1;
        in_wb[i]          = wb;
        in_wid[i*NW +: NW] = NW'(wid);
        in_rd[i*NR +: NR] = NR'(rd);
        in_PC[i*32 +: 32] = 32'h1000 + 32'(tag * 16 + i);
        in_tmask[i*NT +: NT] = NT'((tag + i) % 16);
        in_eop[i]         = 1'((tag + i) % 2);
        for (int t = 0; t < NT; t++)
            in_data[(i*NT + t)*32 +: 32] = {16'(tag), 8'(i), 8'(t)};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        in_valid = '0; in_wb = '0; in_wid = '0; in_PC = '0; in_tmask = '0;
        in_rd = '0; in_data = '0; in_eop = '0;
        out_ready = '1;
        tick(); tick();
        chk_en = 1;
        @(negedge clk);
        chk("reset_out_valid", 256'(out_valid), 256'(0));
        chk("reset_perf", 256'(perf), 256'(0));
        chk("reset_in_ready", 256'(in_ready), 256'(0));
        tick();
        reset = 1'b1;
        tick();

        // Three distinct writebacks across two lanes.
        set_src(0, 1, 0, 8, 1); set_src(2, 1, 0, 10, 1); set_src(4, 1, 0, 12, 1);
        @(negedge clk); chk("t1_ready0", 256'(in_ready), 256'(6'b000101));
        tick(); in_valid[0] = 0; in_valid[2] = 0;
        @(negedge clk);
        chk("t1_valid1", 256'(out_valid), 256'(2'b11));
        chk("t1_rd1", 256'(out_rd), 256'({6'd10, 6'd8}));
        chk("t1_ready1", 256'(in_ready), 256'(6'b010000));
        tick(); in_valid[4] = 0;
        @(negedge clk);
        chk("t1_valid2", 256'(out_valid), 256'(2'b01));
        chk("t1_rd2", 256'(out_rd[5:0]), 256'(6'd12));
        chk("t1_perf2", 256'(perf), 256'(2));
        tick();
        @(negedge clk); chk("t1_perf3", 256'(perf), 256'(3));
        tick();

        // Same (wid, rd) on sources 1 and 3 serialises.
        set_src(1, 1, 1, 5, 2); set_src(3, 1, 1, 5, 2);
        @(negedge clk); chk("t2_ready0", 256'(in_ready), 256'(6'b000010));
        tick(); in_valid[1] = 0;
        @(negedge clk);
        chk("t2_ready1", 256'(in_ready), 256'(6'b001000));
        chk("t2_valid1", 256'(out_valid), 256'(2'b01));
        chk("t2_pc1", 256'(out_PC[31:0]), 256'(32'h1021));
        tick(); in_valid[3] = 0;
        @(negedge clk);
        chk("t2_pc2", 256'(out_PC[31:0]), 256'(32'h1023));
        tick();

        // Stall: lane held, only the no-writeback commit is acknowledged.
        set_src(0, 1, 0, 20, 3);
        @(negedge clk); chk("t3_ready0", 256'(in_ready), 256'(6'b000001));
        tick();
        out_ready = 2'b00;
        set_src(0, 1, 0, 21, 4); set_src(1, 1, 0, 22, 4); set_src(5, 1, 0, 23, 4);
        set_src(2, 0, 0, 1, 4);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t3_stall_ready", 256'(in_ready), 256'(6'b000100));
            chk("t3_stall_valid", 256'(out_valid), 256'(2'b01));
            chk("t3_stall_pc", 256'(out_PC[31:0]), 256'(32'h1030));
            chk("t3_stall_perf", 256'(perf), 256'(5));
            tick();
        end
        in_valid[2] = 0; out_ready = 2'b11;
        @(negedge clk); chk("t4_release_ready", 256'(in_ready), 256'(6'b100010));
        tick(); in_valid[1] = 0; in_valid[5] = 0;
        @(negedge clk);
        chk("t4_valid", 256'(out_valid), 256'(2'b11));
        chk("t4_rd", 256'(out_rd), 256'({6'd23, 6'd22}));
        chk("t4_ready", 256'(in_ready), 256'(6'b000001));
        tick(); in_valid[0] = 0;
        @(negedge clk); chk("t4_rd_last", 256'(out_rd[5:0]), 256'(6'd21));
        tick();
        @(negedge clk); chk("t4_perf", 256'(perf), 256'(9));
        tick();

        // All sources continuously valid: priority mode starves the tail.
        for (int i = 0; i < N; i++) set_src(i, 1, i % 4, 30 + i, 5);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t5_p_ready", 256'(p_in_ready), 256'(6'b000011));
            if (c > 0) begin
                chk("t5_p_valid", 256'(p_out_valid), 256'(2'b11));
                chk("t5_p_rd", 256'(p_out_rd), 256'({6'd31, 6'd30}));
            end
            tick();
        end

        // One-cycle reset in the middle of the burst.
        reset = 1'b0;
        @(negedge clk);
        chk("t6_rst_ready", 256'(in_ready), 256'(0));
        chk("t6_rst_p_ready", 256'(p_in_ready), 256'(0));
        tick(); reset = 1'b1;
        @(negedge clk);
        chk("t6_valid", 256'(out_valid), 256'(0));
        chk("t6_perf", 256'(perf), 256'(0));
        chk("t6_ready", 256'(in_ready), 256'(6'b000011));
        tick();
        @(negedge clk);
        chk("t6_valid2", 256'(out_valid), 256'(2'b11));
        chk("t6_rd2", 256'(out_rd), 256'({6'd31, 6'd30}));
        chk("t6_ready2", 256'(in_ready), 256'(6'b001100));
        tick();
        in_valid = '0;
        tick(); tick();
        @(negedge clk);
        chk("end_idle_valid", 256'(out_valid), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
